// File: rtl/definitions_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | definitions_pkg : shared constants and frame-sender state encoding          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package definitions_pkg;

  localparam int         FIFO_WIDTH = 8;
  localparam logic [7:0] FRAME_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4,
    FIN   = 3'd5
`ifdef FRAME_CKSUM_EN
    ,
    CKSUM = 3'd6
`endif
  } frame_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_frame_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_frame_sender : streams header + frame-buffer pixels into the UART FIFO |
// | Optional trailing checksum byte when FRAME_CKSUM_EN is defined.            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_frame_sender
  import definitions_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [7:0]            rd_data,
  output logic [FIFO_WIDTH-1:0] tx_wr_data,
  output logic                  tx_wr,
  input  logic                  tx_full
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [15:0]       W16      = 16'(IMG_W);
  localparam logic [15:0]       H16      = 16'(IMG_H);

  frame_state_e      state, state_nx;
  logic [2:0]        hdr_idx;
  logic [ADDR_W-1:0] pix_cnt;
  logic [7:0]        pixel;
  logic [7:0]        hdr_byte;
`ifdef FRAME_CKSUM_EN
  logic [7:0]        cksum;
`endif

  always_comb begin
    case (hdr_idx)
      3'd0:    hdr_byte = FRAME_SYNC;
      3'd1:    hdr_byte = W16[15:8];
      3'd2:    hdr_byte = W16[7:0];
      3'd3:    hdr_byte = H16[15:8];
      3'd4:    hdr_byte = H16[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Outputs depend on tx_full combinationally so a stalled byte is never written.
  always_comb begin
    state_nx   = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    tx_wr      = 1'b0;
    tx_wr_data = '0;
    case (state)
      IDLE: if (start) state_nx = HDR;
      HDR: begin
        tx_wr_data = hdr_byte;
        if (!tx_full) begin
          tx_wr = 1'b1;
          if (hdr_idx == 3'd4) state_nx = FETCH;
        end
      end
      FETCH: begin
        rd_en    = 1'b1;
        rd_addr  = pix_cnt;
        state_nx = WAIT;
      end
      WAIT: state_nx = SEND;
      SEND: begin
        tx_wr_data = pixel;
        if (!tx_full) begin
          tx_wr = 1'b1;
          if (pix_cnt != LAST_PIX) state_nx = FETCH;
`ifdef FRAME_CKSUM_EN
          else                     state_nx = CKSUM;
`else
          else                     state_nx = FIN;
`endif
        end
      end
`ifdef FRAME_CKSUM_EN
      CKSUM: begin
        tx_wr_data = cksum;
        if (!tx_full) begin
          tx_wr    = 1'b1;
          state_nx = FIN;
        end
      end
`endif
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_idx <= '0;
      pix_cnt <= '0;
      pixel   <= '0;
`ifdef FRAME_CKSUM_EN
      cksum   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          hdr_idx <= '0;
          pix_cnt <= '0;
`ifdef FRAME_CKSUM_EN
          cksum   <= '0;
`endif
        end
        HDR: if (!tx_full) hdr_idx <= (hdr_idx == 3'd4) ? 3'd0 : hdr_idx + 3'd1;
        WAIT: pixel <= rd_data;
        SEND: if (!tx_full) begin
`ifdef FRAME_CKSUM_EN
          cksum <= cksum + pixel;
`endif
          // Holding at the last index keeps the counter from wrapping mid-frame.
          if (pix_cnt != LAST_PIX) pix_cnt <= pix_cnt + 1'b1;
        end
        FIN: pix_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_sender.sv
`default_nettype none
// Testbench for uart_frame_sender: random pixels and back-pressure against a
// byte-queue model of the frame format.
module tb_uart_frame_sender;
  import definitions_pkg::*;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int AW   = 4;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst, start, tx_full;
  logic          busy, done, rd_en, tx_wr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    tx_wr_data;

  uart_frame_sender #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_wr_data(tx_wr_data), .tx_wr(tx_wr), .tx_full(tx_full)
  );

  always #5 clk = ~clk;

  logic [7:0]    mem [16];
  logic [7:0]    got[$];
  logic [7:0]    exp_q[$];
  int            vectors = 0, miscompares = 0, done_cnt = 0, viol = 0;
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_cap  = '0;

  // Observe at the falling edge: values seen here are what the next rising edge acts on.
  always @(negedge clk) begin
    rd_pend = rd_en;
    rd_cap  = rd_addr;
    if (tx_wr) got.push_back(tx_wr_data);
    if (tx_wr && tx_full) viol++;
    if (done) done_cnt++;
  end

  // Frame-buffer model: data valid exactly one cycle after rd_en, garbage otherwise.
  always @(posedge clk) rd_data <= rd_pend ? mem[rd_cap] : 8'($urandom);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic build_exp();
    int s;
    s = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(W >> 8));
    exp_q.push_back(8'(W));
    exp_q.push_back(8'(H >> 8));
    exp_q.push_back(8'(H));
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back(mem[i]);
      s += int'(mem[i]);
    end
`ifdef FRAME_CKSUM_EN
    exp_q.push_back(8'(s));
`endif
  endtask

  task automatic compare_frame(input string name);
    logic [31:0] v;
    chk({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      v = (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF;
      chk($sformatf("%s_byte%0d", name, i), v, 32'(exp_q[i]));
    end
  endtask

  task automatic run_frame(input string name, input int stall_at, input bit rand_full,
                           input bit restart);
    int cyc, stall_left;
    bit stalled;
    got.delete();
    done_cnt = 0;
    viol     = 0;
    build_exp();
    start = 1'b1;
    step();
    start = 1'b0;
    chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
    cyc = 0; stall_left = 0; stalled = 1'b0;
    while (done_cnt == 0 && cyc < 2000) begin
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) tx_full = 1'b0;
      end else if (stall_at >= 0 && !stalled && got.size() == stall_at) begin
        stalled    = 1'b1;
        tx_full    = 1'b1;
        stall_left = 10;
      end else if (rand_full) begin
        tx_full = 1'($urandom_range(0, 1));
      end
      start = (restart && (cyc == 2 || cyc == 10 || cyc == 20)) ? 1'b1 : 1'b0;
      step();
      cyc++;
    end
    start   = 1'b0;
    tx_full = 1'b0;
    chk({name, "_done_in_time"}, 32'(cyc < 2000), 32'd1);
    repeat (5) step();
    chk({name, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    chk({name, "_no_wr_when_full"}, 32'(viol), 32'd0);
    compare_frame(name);
  endtask

  initial begin
    int cyc, sz;
    rst = 1'b1; start = 1'b0; tx_full = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_tx_wr", 32'(tx_wr), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_tx_wr_data", 32'(tx_wr_data), 32'd0);
    rst = 1'b0;
    step();

    run_frame("basic", -1, 1'b0, 1'b0);
    run_frame("stall_pix3", 7, 1'b0, 1'b0);
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    run_frame("rand_full", -1, 1'b1, 1'b0);
    run_frame("restart_ignored", -1, 1'b0, 1'b1);
    for (int i = 0; i < NPIX; i++) mem[i] = 8'hFF;
    run_frame("all_ff", -1, 1'b1, 1'b0);

    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    got.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (got.size() < 6 && cyc < 500) begin
      step();
      cyc++;
    end
    chk("mid_reached_6", 32'(got.size() >= 6), 32'd1);
    rst = 1'b1;
    #1;
    sz = got.size();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tx_wr", 32'(tx_wr), 32'd0);
    repeat (4) step();
    chk("mid_rst_no_bytes", 32'(got.size()), 32'(sz));
    rst = 1'b0;
    step();
    run_frame("after_reset", -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
